counter_snapshot_reader: RTL and testbench

- Downstream consumer of the atomic counter block; produces coherent 64-bit counter snapshots for a host.
- The counter exposes 32-bit data with `req`/`atomic`/`ack` signalling. This block issues a back-to-back LSB read then MSB (atomic) read, and assembles the two halves.
- Presents each snapshot plus a modular delta from the previous snapshot on a valid/ready host interface.
- Flags a protocol error if an ack is missing.

---
 rtl/counter_snapshot_reader_pkg.sv | 15 +
 rtl/counter_snapshot_reader_if.sv | 33 +++
 rtl/snap_delta_calc.sv | 40 ++++
 rtl/counter_snapshot_reader.sv | 105 ++++++++++
 tb/tb_counter_snapshot_reader.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_snapshot_reader_pkg.sv
// rtl/counter_snapshot_reader_pkg.sv - shared widths and FSM state encoding for the snapshot reader
package counter_pkg;

    localparam int DATABUS  = 32;
    localparam int COUNTLEN = 64;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WAIT_HI,
        VALID
    } snap_state_e;

endpackage

// File: rtl/counter_snapshot_reader_if.sv
// rtl/counter_snapshot_reader_if.sv - host snapshot handshake plus counter read bus
interface counter_snapshot_reader_if #(
    parameter int DATABUS  = counter_pkg::DATABUS,
    parameter int COUNTLEN = counter_pkg::COUNTLEN
);

    logic                snap_req_i;
    logic                snap_valid_o;
    logic                snap_ready_i;
    logic [COUNTLEN-1:0] snap_data_o;
    logic [COUNTLEN-1:0] snap_delta_o;
    logic                snap_first_o;
    logic                busy_o;
    logic                err_o;
    logic                req_o;
    logic                atomic_o;
    logic                ack_i;
    logic [DATABUS-1:0]  count_i;

    // Environment side: host plus atomic counter.
    modport master (
        output snap_req_i, snap_ready_i, ack_i, count_i,
        input  snap_valid_o, snap_data_o, snap_delta_o, snap_first_o,
               busy_o, err_o, req_o, atomic_o
    );

    modport slave (
        input  snap_req_i, snap_ready_i, ack_i, count_i,
        output snap_valid_o, snap_data_o, snap_delta_o, snap_first_o,
               busy_o, err_o, req_o, atomic_o
    );

endinterface

// File: rtl/snap_delta_calc.sv
// rtl/snap_delta_calc.sv - previous-snapshot history and modular delta
module snap_delta_calc #(
    parameter int COUNTLEN = counter_pkg::COUNTLEN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                accept_i,
    input  logic [COUNTLEN-1:0] snap_i,
    output logic [COUNTLEN-1:0] delta_o,
    output logic                first_o
);
    import counter_pkg::*;

    logic [COUNTLEN-1:0] prev_q, prev_d;
    logic                first_q, first_d;

    always_comb begin
        prev_d  = prev_q;
        first_d = first_q;
        if (accept_i) begin
            prev_d  = snap_i;
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q  <= '0;
            first_q <= 1'b1;
        end else begin
            prev_q  <= prev_d;
            first_q <= first_d;
        end
    end

    // Unsigned subtraction wraps naturally mod 2^COUNTLEN.
    assign delta_o = snap_i - prev_q;
    assign first_o = first_q;

endmodule

// File: rtl/counter_snapshot_reader.sv
// rtl/counter_snapshot_reader.sv - LSB-then-MSB(atomic) reader assembling coherent 64-bit snapshots
module counter_snapshot_reader #(
    parameter int DATABUS  = counter_pkg::DATABUS,
    parameter int COUNTLEN = counter_pkg::COUNTLEN
) (
    input  logic                      clk,
    input  logic                      reset,
    counter_snapshot_reader_if.slave  bus
);
    import counter_pkg::*;

    snap_state_e         state_q, state_d;
    logic [DATABUS-1:0]  lo_q, lo_d;
    logic [DATABUS-1:0]  hi_q, hi_d;
    logic                req_q, atomic_q, err_q, err_d;
    logic                valid;
    logic                accept;
    logic                first;
    logic [COUNTLEN-1:0] snap_data;
    logic [COUNTLEN-1:0] snap_delta;

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.snap_req_i) state_d = RD_LO;
            end
            RD_LO: begin
                state_d = RD_HI;
            end
            // The ack seen here belongs to the LSB request issued in RD_LO.
            RD_HI: begin
                if (bus.ack_i) begin
                    lo_d    = bus.count_i;
                    state_d = WAIT_HI;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_HI: begin
                if (bus.ack_i) begin
                    hi_d    = bus.count_i;
                    state_d = VALID;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            VALID: begin
                if (bus.snap_ready_i) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // req/atomic are decoded from the next state so they leave a flop, not a comb path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            req_q    <= 1'b0;
            atomic_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            req_q    <= (state_d == RD_LO) || (state_d == RD_HI);
            atomic_q <= (state_d == RD_HI);
            err_q    <= err_d;
        end
    end

    assign valid     = (state_q == VALID);
    assign accept    = valid && bus.snap_ready_i;
    assign snap_data = {hi_q, lo_q};

    snap_delta_calc #(
        .COUNTLEN (COUNTLEN)
    ) u_delta (
        .clk      (clk),
        .reset    (reset),
        .accept_i (accept),
        .snap_i   (snap_data),
        .delta_o  (snap_delta),
        .first_o  (first)
    );

    assign bus.snap_valid_o = valid;
    assign bus.snap_data_o  = snap_data;
    assign bus.snap_delta_o = snap_delta;
    assign bus.snap_first_o = valid && first;
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.err_o        = err_q;
    assign bus.req_o        = req_q;
    assign bus.atomic_o     = atomic_q;

endmodule

// File: tb/tb_counter_snapshot_reader.sv
// tb/tb_counter_snapshot_reader.sv - scoreboard bench with a behavioural atomic counter
module tb_counter_snapshot_reader;
    import counter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    counter_snapshot_reader_if #(.DATABUS(DATABUS), .COUNTLEN(COUNTLEN)) bus ();

    counter_snapshot_reader #(
        .DATABUS  (DATABUS),
        .COUNTLEN (COUNTLEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counter value in a cycle is cnt_base + inc * (cycles since load).
    logic [63:0] cyc      = '0;
    logic [63:0] cyc_base = '0;
    logic [63:0] cnt_base = '0;
    logic [63:0] inc      = '0;
    logic [31:0] cdata    = '0;
    logic [31:0] shadow   = '0;
    logic        ack_q    = 1'b0;
    bit          suppress_lo = 1'b0;

    function automatic logic [63:0] cnt_at(input logic [63:0] c);
        return cnt_base + inc * (c - cyc_base);
    endfunction

    always @(posedge clk) begin
        logic [63:0] nxt;
        nxt = cnt_at(cyc + 64'd1);
        cyc <= cyc + 64'd1;
        ack_q <= bus.req_o && !(suppress_lo && !bus.atomic_o);
        if (bus.req_o && !bus.atomic_o) begin
            cdata  <= nxt[31:0];
            shadow <= nxt[63:32];
        end else if (bus.req_o && bus.atomic_o) begin
            cdata <= shadow;
        end
    end

    assign bus.ack_i   = ack_q;
    assign bus.count_i = cdata;

    logic [63:0] exp_q[$];
    logic [63:0] prev_m  = '0;
    bit          first_m = 1'b1;
    int          accepts = 0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset) begin
            exp_q.delete();
            prev_m  = '0;
            first_m = 1'b1;
        end else begin
            if (bus.req_o && bus.atomic_o && bus.ack_i)
                exp_q.push_back(cnt_at(cyc));
            if (bus.snap_valid_o && bus.snap_ready_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_data", bus.snap_data_o, e);
                    check_eq("sb_delta", bus.snap_delta_o, e - prev_m);
                    check_eq("sb_first", {63'd0, bus.snap_first_o}, {63'd0, first_m});
                    prev_m  = e;
                    first_m = 1'b0;
                    accepts++;
                end
            end
        end
    end

    task automatic set_count(input logic [63:0] v, input logic [63:0] step_by);
        cnt_base = v;
        cyc_base = cyc;
        inc      = step_by;
    endtask

    task automatic start_snap();
        bus.snap_req_i = 1'b1;
        @(posedge clk);
        #1 bus.snap_req_i = 1'b0;
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.snap_valid_o) seen = 1'b1;
        end
        if (!seen) check_eq("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, {63'd0, bus.snap_valid_o}, 64'd0);
        check_eq({tag, "_busy"},  {63'd0, bus.busy_o},       64'd0);
        check_eq({tag, "_req"},   {63'd0, bus.req_o},        64'd0);
        check_eq({tag, "_atomic"},{63'd0, bus.atomic_o},     64'd0);
        check_eq({tag, "_err"},   {63'd0, bus.err_o},        64'd0);
        check_eq({tag, "_first"}, {63'd0, bus.snap_first_o}, 64'd0);
        check_eq({tag, "_data"},  bus.snap_data_o,           64'd0);
        check_eq({tag, "_delta"}, bus.snap_delta_o,          64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_cnt;
        int val_cnt;
        int acc_start;
        reset            = 1'b0;
        bus.snap_req_i   = 1'b0;
        bus.snap_ready_i = 1'b1;
        set_count(64'd0, 64'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        @(posedge clk);
        #1 reset = 1'b1;

        // Static counter: exact req/atomic sequence and four-cycle latency.
        set_count(64'h0000_0005_0000_0007, 64'd0);
        start_snap();
        @(negedge clk);
        check_eq("t1_req_lo",    {63'd0, bus.req_o},    64'd1);
        check_eq("t1_atomic_lo", {63'd0, bus.atomic_o}, 64'd0);
        @(negedge clk);
        check_eq("t1_req_hi",    {63'd0, bus.req_o},    64'd1);
        check_eq("t1_atomic_hi", {63'd0, bus.atomic_o}, 64'd1);
        @(negedge clk);
        check_eq("t1_req_wait",  {63'd0, bus.req_o},    64'd0);
        check_eq("t1_busy_wait", {63'd0, bus.busy_o},   64'd1);
        check_eq("t1_valid_early", {63'd0, bus.snap_valid_o}, 64'd0);
        @(negedge clk);
        check_eq("t1_valid", {63'd0, bus.snap_valid_o}, 64'd1);
        check_eq("t1_data",  bus.snap_data_o, 64'h0000_0005_0000_0007);
        check_eq("t1_first", {63'd0, bus.snap_first_o}, 64'd1);
        realign();

        // Incrementing counter across the 32-bit carry boundary.
        acc_start = accepts;
        set_count(64'h0000_0000_FFFF_FFF6, 64'd1);
        bus.snap_req_i = 1'b1;
        repeat (40) @(posedge clk);
        #1 bus.snap_req_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("t2_count", {63'd0, (accepts - acc_start) >= 6}, 64'd1);

        // Delta between two known snapshots, then wrap-around delta.
        set_count(64'h10, 64'd0);
        start_snap();
        wait_valid();
        realign();
        set_count(64'h3E8, 64'd0);
        start_snap();
        wait_valid();
        check_eq("t3_first", {63'd0, bus.snap_first_o}, 64'd0);
        check_eq("t3_delta", bus.snap_delta_o, 64'h3D8);
        realign();
        set_count(64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        start_snap();
        wait_valid();
        realign();
        set_count(64'h1, 64'd0);
        start_snap();
        wait_valid();
        check_eq("t3_wrap_data",  bus.snap_data_o,  64'h1);
        check_eq("t3_wrap_delta", bus.snap_delta_o, 64'h2);
        realign();

        // Backpressure: held output, no new reads, request pulses ignored.
        bus.snap_ready_i = 1'b0;
        set_count(64'h1234_5678_9ABC_DEF0, 64'd1);
        start_snap();
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 bus.snap_req_i = (i == 2 || i == 5 || i == 7);
            @(negedge clk);
            check_eq("bp_valid", {63'd0, bus.snap_valid_o}, 64'd1);
            check_eq("bp_req",   {63'd0, bus.req_o},        64'd0);
            check_eq("bp_data",  bus.snap_data_o,  exp_q.size() > 0 ? exp_q[0] : 64'hDEAD);
            check_eq("bp_delta", bus.snap_delta_o, (exp_q.size() > 0 ? exp_q[0] : 64'hDEAD) - prev_m);
        end
        @(posedge clk);
        #1 bus.snap_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_idle_busy",  {63'd0, bus.busy_o},       64'd0);
        check_eq("bp_idle_valid", {63'd0, bus.snap_valid_o}, 64'd0);
        @(negedge clk);
        check_eq("bp_no_queue", {63'd0, bus.busy_o}, 64'd0);
        realign();

        // Missing LSB ack: single error pulse, no snapshot, history kept.
        suppress_lo = 1'b1;
        start_snap();
        err_cnt = 0;
        val_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.err_o) err_cnt++;
            if (bus.snap_valid_o) val_cnt++;
        end
        check_eq("err_pulses", 64'(err_cnt), 64'd1);
        check_eq("err_valid",  64'(val_cnt), 64'd0);
        realign();
        suppress_lo = 1'b0;
        set_count(64'h2000, 64'd0);
        start_snap();
        wait_valid();
        check_eq("err_next_first", {63'd0, bus.snap_first_o}, 64'd0);
        check_eq("err_next_delta", bus.snap_delta_o, 64'h2000 - prev_m);
        realign();

        // Asynchronous reset during WAIT_HI.
        set_count(64'hABCD, 64'd0);
        start_snap();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_pre_busy", {63'd0, bus.busy_o}, 64'd1);
        #1 reset = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        set_count(64'h77, 64'd0);
        start_snap();
        wait_valid();
        check_eq("post_rst_first", {63'd0, bus.snap_first_o}, 64'd1);
        check_eq("post_rst_delta", bus.snap_delta_o, 64'h77);
        realign();
        realign();

        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
